// File: rtl/gt_ctrl_pkg.sv
// Shared definitions for the bit-serial arithmetic-unit controllers:
// FSM state encodings and the parameter legality check.
package gt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gt_state_e;

  // Legal when BPC is a power of two up to 16 that divides a width of at least 2.
  function automatic bit bpc_legal(input int width, input int bpc);
    bit bpc_ok;
    bpc_ok = (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    return bpc_ok && (width >= 2) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/gt_serial_cell.sv
// One bit of the serial B-A subtract-compare; the MSB cell resolves the sign
// and produces the final A > B result.
module gt_serial_cell (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  input  logic is_msb,
  output logic borrow_out,
  output logic gt
);

  assign borrow_out = (~b & a) | (~(a ^ b) & borrow_in);
  // Differing sign bits decide directly: B negative means A is greater.
  assign gt = is_msb ? ((a != b) ? b : borrow_in) : borrow_out;

endmodule

// File: rtl/gt_int_serial_ctrl.sv
// Sequencer for a bit-serial signed A > B compare: accepts an operand pair,
// walks it LSB-first BPC bits per cycle, and returns Y on a valid/ready port.
module gt_int_serial_ctrl
  import gt_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds valid and data stable until that edge.

  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N) + 1;

  if (!bpc_legal(WIDTH, BPC)) begin : g_bad_param
    $error("gt_int_serial_ctrl: illegal WIDTH=%0d / BPC=%0d", WIDTH, BPC);
  end

  gt_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             borrow_q;
  logic             y_q;

  logic             last_chunk;
  logic [BPC:0]     chain;
  logic [BPC-1:0]   gt_bit;
  logic [BPC-1:0]   msb_vec;
  logic             y_sel;

  assign last_chunk = (cnt_q == CW'(N - 1));
  assign chain[0]   = borrow_q;
  // Only the top cell of the final chunk sees the sign bits.
  assign msb_vec    = last_chunk ? (BPC'(1) << (BPC - 1)) : '0;
  assign y_sel      = |(gt_bit & msb_vec);

  for (genvar j = 0; j < BPC; j++) begin : g_cell
    gt_serial_cell u_cell (
      .a          (a_sh[j]),
      .b          (b_sh[j]),
      .borrow_in  (chain[j]),
      .is_msb     (msb_vec[j]),
      .borrow_out (chain[j+1]),
      .gt         (gt_bit[j])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_RUN;
      ST_RUN:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      borrow_q <= 1'b0;
      y_q      <= 1'b0;
    end else if (state_q == ST_IDLE && in_valid) begin
      cnt_q    <= '0;
      a_sh     <= A;
      b_sh     <= B;
      borrow_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      cnt_q    <= cnt_q + CW'(1);
      a_sh     <= a_sh >> BPC;
      b_sh     <= b_sh >> BPC;
      borrow_q <= chain[BPC];
      if (last_chunk) y_q <= y_sel;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign Y         = y_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gt_int_serial_ctrl.sv
// Bench for gt_int_serial_ctrl: five instances (BPC = 1,2,4,8,16, WIDTH = 16)
// exercised with directed vectors, backpressure, mid-run reset and a random sweep.
module tb_gt_int_serial_ctrl;

  localparam int NI = 5;

  logic            clk;
  logic            rst;
  logic [15:0]     a_in, b_in;
  logic [NI-1:0]   in_valid, out_ready;
  wire  [NI-1:0]   in_ready, out_valid, y, busy;
  wire  [1:0]      st_dbg [NI];

  int tests  = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gt_int_serial_ctrl #(.WIDTH(16), .BPC(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .A         (a_in),
      .B         (b_in),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .Y         (y[g]),
      .busy      (busy[g]),
      .state_dbg (st_dbg[g])
    );
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a pair on instance k and return just after the accept edge.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    @(negedge clk);
    a_in = a;
    b_in = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 200), 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid, then check latency and Y.
  task automatic wait_result(input int k, input logic exp_y, input string tag);
    int j;
    j = 0;
    @(negedge clk);
    while (!out_valid[k] && j < 100) begin
      @(negedge clk);
      j++;
    end
    check({tag, "_lat"}, j, 16 >> k);
    check({tag, "_y"}, y[k], exp_y);
    check({tag, "_busy"}, busy[k], 1);
    check({tag, "_in_ready_done"}, in_ready[k], 0);
  endtask

  task automatic op(input int k, input logic [15:0] a, input logic [15:0] b,
                    input logic exp_y, input string tag);
    send(k, a, b);
    wait_result(k, exp_y, tag);
    @(negedge clk);
    check({tag, "_in_ready_next"}, in_ready[k], 1);
    check({tag, "_out_valid_next"}, out_valid[k], 0);
  endtask

  // Random sweep with 50% in_valid / out_ready and a golden expected queue.
  task automatic sweep(input int k, input int nops);
    int acc, cyc;
    bit pend;
    logic [15:0] pa, pb;
    acc = 0;
    cyc = 0;
    pend = 1'b0;
    pa = '0;
    pb = '0;
    exp_q.delete();
    while ((acc < nops || pend || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!pend && acc < nops && $urandom_range(0, 1) == 1) begin
        pa = 16'($urandom);
        pb = ($urandom_range(0, 7) == 0) ? pa : 16'($urandom);
        pend = 1'b1;
      end
      a_in = pa;
      b_in = pb;
      in_valid[k]  = pend;
      out_ready[k] = 1'($urandom_range(0, 1));
      if (out_valid[k] && out_ready[k]) begin
        if (exp_q.size() == 0) check("sweep_unexpected_result", exp_q.size(), 1);
        else check($sformatf("sweep_bpc%0d_y", 1 << k), y[k], exp_q.pop_front());
      end
      if (pend && in_ready[k]) begin
        exp_q.push_back($signed(pa) > $signed(pb));
        pend = 1'b0;
        acc++;
      end
    end
    check($sformatf("sweep_bpc%0d_done", 1 << k), 32'(cyc < 20000), 1);
    @(negedge clk);
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0;
    b_in = '0;
    in_valid  = '0;
    out_ready = '1;
    #2;
    for (int k = 0; k < NI; k++) begin
      check("rst_in_ready", in_ready[k], 1);
      check("rst_out_valid", out_valid[k], 0);
      check("rst_busy", busy[k], 0);
      check("rst_y", y[k], 0);
      check("rst_state", st_dbg[k], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic and signed corners, BPC=1
    op(0, 16'd5,    16'd3,    1'b1, "a5_b3");
    op(0, 16'h7FFF, 16'h8000, 1'b1, "max_gt_min");
    op(0, 16'hFFFF, 16'h0000, 1'b0, "neg1_vs_0");
    op(0, 16'h1234, 16'h1234, 1'b0, "equal");
    op(0, 16'h8000, 16'h8001, 1'b0, "min_vs_min1");

    // Backpressure: hold DONE for 5 cycles while a new pair competes
    out_ready[0] = 1'b0;
    send(0, 16'd3, 16'd2);
    wait_result(0, 1'b1, "bp_first");
    a_in = 16'd5;
    b_in = 16'd1;
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_valid", out_valid[0], 1);
      check("bp_y", y[0], 1);
      check("bp_busy", busy[0], 1);
      check("bp_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", in_ready[0], 1);
    check("bp_release_out_valid", out_valid[0], 0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_result(0, 1'b1, "bp_held");
    @(negedge clk);

    // Asynchronous reset seven cycles into RUN
    send(0, 16'd1, 16'd0);
    repeat (7) @(posedge clk);
    #2;
    check("mid_run_busy", busy[0], 1);
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid[0], 0);
    check("arst_busy", busy[0], 0);
    check("arst_y", y[0], 0);
    check("arst_in_ready", in_ready[0], 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready[0], 1);
    op(0, 16'd0, 16'd1, 1'b0, "post_rst");

    // Wider chunks
    op(1, 16'h8000, 16'h7FFF, 1'b0, "bpc2_min_vs_max");
    op(2, 16'h0100, 16'h00FF, 1'b1, "bpc4_carry");
    op(3, 16'hFFFE, 16'hFFFD, 1'b1, "bpc8_neg");
    op(4, 16'h0100, 16'h00FF, 1'b1, "bpc16_carry");
    op(4, 16'h8000, 16'h0000, 1'b0, "bpc16_neg");

    for (int k = 0; k < NI; k++) sweep(k, 300);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
